// File: rtl/mem_ctrl.sv
// Word-addressed RAM port behind the MAR: latches a request, waits WAIT_STATES cycles, accesses, pulses ready.
// Optional address fault checking is enabled by defining MEM_ADDR_FAULT_EN.
module mem_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              ready,
    output logic              err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               mem_we;
    logic               fault;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  mem [DEPTH];

    assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_ADDR_FAULT_EN
    logic err_q, err_d;
    assign fault = (addr_q >> IDX_W) != '0;
    assign err_d = ready_d && fault;
    assign err   = err_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    // Upper address bits only matter for fault detection; without it they alias away.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr_q >> IDX_W};
    assign fault = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        data_d  = data_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    is_wr_d = wr_req;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (is_wr_q) mem_we = !fault;
                else         data_d = fault ? '0 : mem[idx];
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // RAM is not reset; an asserted reset holds the FSM in IDLE so no write can fire.
    always_ff @(posedge clock) begin
        if (mem_we) mem[idx] <= wdata_q;
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl: three instances with WAIT_STATES 0, 1 and 4 against a behavioural model.
module tb_mem_ctrl;
`ifdef MEM_ADDR_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [2:0]  rd_req = '0, wr_req = '0;
    logic [2:0]  busy, ready, err;
    logic [15:0] dout [3];

    int unsigned n_checks = 0, n_fail = 0;

    // Model state: per-instance memory image, written flags and expected data_out.
    logic [15:0] mem_m   [3][256];
    bit          valid_m [3][256];
    logic [15:0] dout_m  [3];
    bit          known_m [3];

    always #5 clock = ~clock;

    mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
        .rd_req(rd_req[0]), .wr_req(wr_req[0]), .data_out(dout[0]),
        .busy(busy[0]), .ready(ready[0]), .err(err[0]));
    mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
        .rd_req(rd_req[1]), .wr_req(wr_req[1]), .data_out(dout[1]),
        .busy(busy[1]), .ready(ready[1]), .err(err[1]));
    mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(4)) u_ws4 (
        .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
        .rd_req(rd_req[2]), .wr_req(wr_req[2]), .data_out(dout[2]),
        .busy(busy[2]), .ready(ready[2]), .err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 4;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            dout_m[i]  = '0;
            known_m[i] = 1'b1;
        end
    endfunction

    // One complete request on instance i; optionally disturbs inputs while the access is in flight.
    task automatic do_op(input int i, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d, input bit disturb);
        int  ws, lat, nbusy;
        bit  seen, flt;
        ws    = ws_of(i);
        flt   = FAULT_EN && (a >= 16'd256);
        @(negedge clock);
        addr = a; data_in = d; rd_req[i] = rd; wr_req[i] = wr;
        @(posedge clock); #1;
        rd_req[i] = 1'b0; wr_req[i] = 1'b0;
        addr = 16'($urandom); data_in = 16'($urandom);

        if (wr) begin
            if (!flt) begin
                mem_m[i][a[7:0]]   = d;
                valid_m[i][a[7:0]] = 1'b1;
            end
        end else if (flt) begin
            dout_m[i] = '0; known_m[i] = 1'b1;
        end else if (valid_m[i][a[7:0]]) begin
            dout_m[i] = mem_m[i][a[7:0]]; known_m[i] = 1'b1;
        end else begin
            known_m[i] = 1'b0;
        end

        lat = 0; nbusy = 0; seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k > 1) begin @(posedge clock); #1; end
            if (busy[i]) nbusy++;
            if (disturb && k == 1) begin addr = 16'h0030; data_in = 16'hDEAD; rd_req[i] = 1'b1; wr_req[i] = 1'b1; end
            if (disturb && k == 2) begin rd_req[i] = 1'b0; wr_req[i] = 1'b0; end
            if (ready[i]) begin seen = 1'b1; lat = k; end
        end
        check($sformatf("latency[%0d]", i), lat, ws + 2);
        check($sformatf("busy_cycles[%0d]", i), nbusy, ws + 2);
        check($sformatf("err[%0d]@%0h", i, a), {31'd0, err[i]}, {31'd0, flt});
        if (known_m[i]) check($sformatf("data_out[%0d]@%0h", i, a), {16'd0, dout[i]}, {16'd0, dout_m[i]});
        @(posedge clock); #1;
        check($sformatf("idle[%0d]", i), {29'd0, ready[i], busy[i], err[i]}, 32'd0);
    endtask

    initial begin
        int c;
        bit hit;
        model_reset();
        for (int i = 0; i < 3; i++) for (int j = 0; j < 256; j++) valid_m[i][j] = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outs[%0d]", i), {13'd0, dout[i], busy[i], ready[i], err[i]}, 32'd0);
        @(negedge clock) reset = 1'b1;

        // Basic write/read with WAIT_STATES=1.
        do_op(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // Latency with 0 and 4 wait states; data_out held across a later write.
        for (int i = 0; i < 3; i += 2) begin
            do_op(i, 1'b0, 1'b1, 16'h0005, 16'h5A00 + 16'(i), 1'b0);
            do_op(i, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
            do_op(i, 1'b0, 1'b1, 16'h0006, 16'h1111, 1'b0);
        end

        // Simultaneous requests: write wins.
        do_op(1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

        // Inputs changed while busy are ignored.
        do_op(1, 1'b0, 1'b1, 16'h0030, 16'h3030, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        do_op(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i += 2) do_op(i, 1'b0, 1'b1, 16'h0007, 16'h7070, 1'b1);
        for (int i = 0; i < 3; i += 2) do_op(i, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0);

        // Out-of-range address: aliases, or faults when checking is enabled.
        do_op(1, 1'b0, 1'b1, 16'h0005, 16'h5555, 1'b0);
        do_op(1, 1'b0, 1'b1, 16'h0105, 16'hAAAA, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0105, 16'h0000, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);

        // Held read request: back-to-back accesses every WAIT_STATES+3 cycles.
        @(negedge clock);
        addr = 16'h0010; rd_req[1] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin @(posedge clock); #1; hit = ready[1]; end
        check("held_first_ready", {31'd0, hit}, 32'd1);
        c = 0; hit = 1'b0;
        while (!hit && c < 20) begin @(posedge clock); #1; c++; hit = ready[1]; end
        rd_req[1] = 1'b0;
        check("held_throughput", c, 4);
        dout_m[1] = mem_m[1][8'h10];
        check("held_data", {16'd0, dout[1]}, {16'd0, dout_m[1]});
        repeat (2) @(posedge clock);

        // Randomized traffic on all instances.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 3; i++) begin
                int unsigned op;
                logic [15:0] a;
                op = $urandom_range(0, 3);
                a  = 16'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0000);
                do_op(i, op != 1, op == 1 || op == 2, a, 16'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        // Reset mid-access aborts a pending write and clears data_out.
        do_op(1, 1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        @(negedge clock);
        addr = 16'h0040; data_in = 16'h7777; wr_req[1] = 1'b1;
        @(posedge clock); #1;
        wr_req[1] = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++)
            check($sformatf("midreset[%0d]", i), {13'd0, dout[i], busy[i], ready[i], err[i]}, 32'd0);
        @(negedge clock) reset = 1'b1;
        do_op(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        do_op(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        check("after_reset_keep", {16'd0, dout[1]}, {16'd0, mem_m[1][8'h10]});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
